pipe_addsub: RTL and testbench
==============================

# pipe_addsub

Parametrised, pipelined adder/subtractor that replaces the single-cycle 32-bit combinational adder used in the lab datapaths. The carry chain is split into CHUNK-bit slices, one slice per pipeline stage, so wide operands close timing at high clock rates. Each stage computes one slice and passes its carry to the next stage. The block adds a subtract mode, carry-out and signed-overflow flags, and a valid/ready handshake with backpressure, and it sits between operand registers and the accumulator/result stage.

## Interface

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits added per pipeline stage; STAGES = WIDTH/CHUNK (≥1) is the latency.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- sub  input  1  0: sum = a + b; 1: sum = a − b.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow.
- out_valid  output  1  sum/cout/ovf valid.
- out_ready  input  1  downstream accepts the result.

## Operation

- Subtract is computed as a + ~b + 1: stage 0 receives b ^ {WIDTH{sub}} and carry-in = sub.
- Stage k (0..STAGES−1) adds slice k (bits k·CHUNK+CHUNK−1 : k·CHUNK) of A and the conditioned B, plus the carry registered by stage k−1.
  - It registers the slice result and the carry out.
  - It forwards the already-computed lower slices and the not-yet-processed upper operand slices.
- Each stage has a valid bit; stage 0 loads in_valid.
- Pipeline enable: en = !out_valid || out_ready.
  - in_ready = en.
  - When en = 0, every stage holds its contents.
  - When en = 1, all stages shift one step and bubbles travel as valid = 0; bubbles are not collapsed.
- An input is accepted when in_valid && in_ready.
- Final stage outputs:
  - sum is the concatenated slices.
  - cout is the carry out of the last slice.
  - ovf = carry into the MSB XOR cout; equivalently, operand sign bits equal and result sign differs (using the conditioned B).
- Outputs are registered; there is no combinational path from a/b to sum.
- Results leave in acceptance order; none are dropped or duplicated.
- The flags are meaningful only while out_valid = 1. They are held stable while out_valid && !out_ready.

## Timing

- Reset, synchronous on the clk edge with reset = 1:
  - All stage valid bits clear, so out_valid = 0.
  - sum = 0, cout = 0, ovf = 0.
  - in_ready = 1 in the cycle after reset.
- Reset mid-operation discards every in-flight result. Inputs presented while reset = 1 are not accepted.
- Latency: an operation accepted at edge n appears with out_valid = 1 after edge n+STAGES, assuming no stall.
- Throughput: 1 operation/cycle while out_ready = 1.
- Stall: if out_valid && !out_ready, then in_ready = 0 in the same cycle (combinational from out_ready). Input must be held by the source.
- Simultaneous accept and output: when out_ready = 1 and in_valid = 1, the pipeline shifts, the final result is consumed, and the new operand enters the same cycle.
- STAGES = 1 (CHUNK = WIDTH): the block reduces to a registered adder with a 1-cycle latency and the same handshake.
- Wrap-around: sum is taken modulo 2^WIDTH. Carry beyond the MSB appears only in cout.

## Test plan

All scenarios use WIDTH=32 and CHUNK=8, so latency is 4.
- Basic add: a=0, b=1, sub=0 -> 4 cycles later sum=0x00000001, cout=0, ovf=0. Then a=1, b=2 -> 0x00000003.
- Cross-slice carry:
  - a=0x0000FFFF, b=1 -> sum=0x00010000.
  - a=0x0000FFFF, b=0x0002CCC1 -> 0x0003CCC0.
  - a=0xFFFFFFFF, b=1 -> sum=0, cout=1, ovf=0.
- Signed overflow and subtract:
  - a=0x7FFFFFFF, b=1 -> 0x80000000, ovf=1.
  - a=1, b=2, sub=1 -> 0xFFFFFFFF, cout=0.
  - a=0x80000000, b=1, sub=1 -> 0x7FFFFFFF, ovf=1, cout=1.
- Streaming with backpressure:
  - Issue 8 back-to-back ops (a=i, b=i·0x01010101, i=0..7), holding out_ready=0 for 3 cycles once the first result appears.
  - Required: in_ready=0 exactly during the stall, all 8 results in order, none lost or duplicated, outputs stable while stalled.
- Bubbles: in_valid pattern 1,0,1,1,0,1 with out_ready=1 -> out_valid pattern identical, shifted by 4 cycles.
- Reset mid-flight: accept 3 ops, assert reset for 1 cycle -> out_valid stays 0 and no stale result appears. The next op (a=5, b=6) returns 0x0000000B after 4 cycles.

Source files
------------

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into CHUNK-bit slices,
// one slice per register stage, with a valid/ready handshake and a global stall.
module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic en;
    logic ovf_d, ovf_q;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;

        // Each stage only carries the operand bits it has not consumed yet.
        logic [WIDTH-1:LO]     src_a;
        logic [WIDTH-1:LO]     src_b;
        logic                  src_c;
        logic                  src_v;
        logic [CHUNK:0]        slice;
        logic [LO+CHUNK-1:0]   s_d;
        logic [LO+CHUNK-1:0]   s_q;
        logic                  c_q;
        logic                  v_q;

        if (k == 0) begin : g_src
            assign src_a = a;
            assign src_b = b ^ {WIDTH{sub}};
            assign src_c = sub;
            assign src_v = in_valid;
            assign s_d   = slice[CHUNK-1:0];
        end else begin : g_src
            assign src_a = g_stage[k-1].g_fwd.a_q;
            assign src_b = g_stage[k-1].g_fwd.b_q;
            assign src_c = g_stage[k-1].c_q;
            assign src_v = g_stage[k-1].v_q;
            assign s_d   = {slice[CHUNK-1:0], g_stage[k-1].s_q};
        end

        assign slice = {1'b0, src_a[LO +: CHUNK]} + {1'b0, src_b[LO +: CHUNK]}
                     + (CHUNK+1)'(src_c);

        always_ff @(posedge clk) begin
            if (reset) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                s_q <= s_d;
                c_q <= slice[CHUNK];
                v_q <= src_v;
            end
        end

        if (k < LAST) begin : g_fwd
            logic [WIDTH-1:LO+CHUNK] a_q;
            logic [WIDTH-1:LO+CHUNK] b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= src_a[WIDTH-1:LO+CHUNK];
                    b_q <= src_b[WIDTH-1:LO+CHUNK];
                end
            end
        end
    end

    // Signed overflow: operand signs agree (with B already conditioned) but the result sign differs.
    assign ovf_d = (g_stage[LAST].src_a[WIDTH-1] == g_stage[LAST].src_b[WIDTH-1])
                && (g_stage[LAST].slice[CHUNK-1] != g_stage[LAST].src_a[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_d;
        end
    end

    assign sum       = g_stage[LAST].s_q;
    assign cout      = g_stage[LAST].c_q;
    assign out_valid = g_stage[LAST].v_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub (WIDTH=32, CHUNK=8, four-cycle latency).
module tb_pipe_addsub;
    localparam int W   = 32;
    localparam int LAT = 4;
    localparam int N   = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sub;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic          out_valid;
    logic          out_ready;

    pipe_addsub #(.WIDTH(W), .CHUNK(8)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .cout(cout),
        .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    vec_t vt [N];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  k;
        int  sent, recv, stall_left;
        bit  stalled, acc, expv;
        bit  pat [6];

        vt[0]  = '{32'h00000000, 32'h00000001, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vt[1]  = '{32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0, 1'b0};
        vt[2]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        vt[3]  = '{32'h0000FFFF, 32'h0002CCC1, 1'b0, 32'h0003CCC0, 1'b0, 1'b0};
        vt[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[5]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[6]  = '{32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vt[7]  = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vt[8]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vt[9]  = '{32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vt[10] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vt[11] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
        pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; a = '0; b = '0;
        step;
        step;
        reset = 1'b0;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_flags", {sum, cout, ovf}, 34'h0);
        step;
        chk("reset_in_ready", in_ready, 1);

        // Back-to-back directed vectors, no stall.
        for (int t = 0; t < N + LAT - 1; t++) begin
            if (t < N) begin
                a = vt[t].a; b = vt[t].b; sub = vt[t].sub; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step;
            if (t >= LAT - 1) begin
                k = t - (LAT - 1);
                chk($sformatf("vec%0d_valid", k), out_valid, 1);
                chk($sformatf("vec%0d_result", k), {sum, cout, ovf}, {vt[k].s, vt[k].c, vt[k].o});
            end else begin
                chk("latency_valid", out_valid, 0);
            end
        end
        in_valid = 1'b0;
        step;
        chk("drain_valid", out_valid, 0);

        // Streaming with a three-cycle stall when the first result shows up.
        sent = 0; recv = 0; stall_left = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (out_valid && !stalled) begin
                stalled    = 1'b1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 8);
            a         = 32'(sent);
            b         = 32'(sent) * 32'h01010101;
            sub       = 1'b0;
            #1;
            chk("stream_in_ready", in_ready, stall_left == 0);
            if (out_valid) begin
                if (recv < 8)
                    chk($sformatf("stream_res%0d", recv), {sum, cout, ovf},
                        {32'(recv) * 32'h01010102, 2'b00});
                else
                    chk("stream_dup", out_valid, 0);
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) recv++;
            step;
            if (acc) sent++;
            if (stall_left > 0) stall_left--;
        end
        chk("stream_recv_count", 64'(recv), 8);
        chk("stream_sent_count", 64'(sent), 8);

        // Bubbles travel through unchanged.
        out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            in_valid = (t < 6) ? pat[t] : 1'b0;
            a = 32'(t); b = 32'h100; sub = 1'b0;
            step;
            if (t >= LAT - 1) begin
                k    = t - (LAT - 1);
                expv = (k < 6) ? pat[k] : 1'b0;
                chk($sformatf("bubble%0d_valid", k), out_valid, expv);
                if (expv) chk($sformatf("bubble%0d_sum", k), sum, 32'(k) + 32'h100);
            end else begin
                chk("bubble_lead_valid", out_valid, 0);
            end
        end

        // Reset with three operations in flight plus one presented during reset.
        for (int t = 0; t < 3; t++) begin
            in_valid = 1'b1; a = 32'(t + 1); b = 32'(t); sub = 1'b0;
            step;
        end
        reset = 1'b1; in_valid = 1'b1; a = 32'hDEAD; b = 32'h1;
        step;
        reset = 1'b0; in_valid = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_in_ready", in_ready, 1);
        a = 32'h5; b = 32'h6; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            step;
            if (j < 3) begin
                chk($sformatf("midrst_stale%0d", j), out_valid, 0);
            end else begin
                chk("midrst_new_valid", out_valid, 1);
                chk("midrst_new_sum", {sum, cout, ovf}, {32'h0000000B, 2'b00});
            end
        end
        step;
        chk("midrst_tail_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
